// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for the decode/execute pipeline register.
// Produces stall, bubble (NOP) and fetch-flush controls plus a saturating stall-cycle counter.
module pipeline_hazard_controller #(
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int MUL_LATENCY          = 5,
  parameter int FLUSH_CYCLES         = 2,
  parameter int COUNT_WIDTH          = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            dec_valid,
  input  logic [REGISTER_INDEX_WIDTH-1:0] dec_rs1,
  input  logic [REGISTER_INDEX_WIDTH-1:0] dec_rs2,
  input  logic                            dec_uses_rs1,
  input  logic                            dec_uses_rs2,
  input  logic                            dec_is_mul,
  input  logic [REGISTER_INDEX_WIDTH-1:0] ex_dest,
  input  logic                            ex_reg_write,
  input  logic                            ex_mem_to_reg,
  input  logic                            ex_branch_taken,
  input  logic                            mem_access,
  input  logic                            mem_ready,
  output logic                            stall_out,
  output logic                            execution_empty_out,
  output logic                            set_nop_out,
  output logic                            flush_fetch_out,
  output logic [COUNT_WIDTH-1:0]          stall_cycles_out
);

  localparam int MUL_CNT_W   = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
  localparam int FLUSH_CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [MUL_CNT_W-1:0]   MUL_INIT   = MUL_CNT_W'(MUL_LATENCY - 2);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [MUL_CNT_W-1:0]     mul_cnt_q, mul_cnt_d;
  logic [FLUSH_CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [COUNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

  logic miss;
  logic load_use;
  logic rs1_match;
  logic rs2_match;

  assign miss      = mem_access & ~mem_ready;
  assign rs1_match = dec_uses_rs1 & (dec_rs1 == ex_dest);
  assign rs2_match = dec_uses_rs2 & (dec_rs2 == ex_dest);
  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use  = ex_mem_to_reg & ex_reg_write & (ex_dest != '0) & dec_valid
                   & (rs1_match | rs2_match);

  always_comb begin
    state_d             = state_q;
    mul_cnt_d           = mul_cnt_q;
    flush_cnt_d         = flush_cnt_q;
    stall_out           = 1'b0;
    execution_empty_out = 1'b1;
    set_nop_out         = 1'b0;
    flush_fetch_out     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_branch_taken) begin
          set_nop_out     = 1'b1;
          flush_fetch_out = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_INIT;
          end
        end else if (miss) begin
          stall_out           = 1'b1;
          execution_empty_out = 1'b0;
          state_d             = MEM_WAIT;
        end else if (load_use) begin
          // One bubble only: the load moves on next cycle and the dependency resolves.
          stall_out   = 1'b1;
          set_nop_out = 1'b1;
        end else if (dec_valid & dec_is_mul) begin
          state_d   = MUL_BUSY;
          mul_cnt_d = MUL_INIT;
        end
      end

      MUL_BUSY: begin
        stall_out           = 1'b1;
        execution_empty_out = 1'b0;
        // A pending d-cache miss freezes the multiply countdown.
        if (!miss) begin
          if (mul_cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            mul_cnt_d = mul_cnt_q - 1'b1;
          end
        end
      end

      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = IDLE;
        end else begin
          stall_out           = 1'b1;
          execution_empty_out = 1'b0;
        end
      end

      FLUSH: begin
        set_nop_out     = 1'b1;
        flush_fetch_out = 1'b1;
        flush_cnt_d     = flush_cnt_q - 1'b1;
        if (flush_cnt_d == '0) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_out && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mul_cnt_q   <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_out = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Testbench for pipeline_hazard_controller: directed scenarios plus randomized traffic
// checked every cycle against a cycles-remaining reference model.
module tb_pipeline_hazard_controller;

  localparam int RW     = 5;
  localparam int MUL_L  = 5;
  localparam int FLUSH_C = 2;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          dec_valid;
  logic [RW-1:0] dec_rs1;
  logic [RW-1:0] dec_rs2;
  logic          dec_uses_rs1;
  logic          dec_uses_rs2;
  logic          dec_is_mul;
  logic [RW-1:0] ex_dest;
  logic          ex_reg_write;
  logic          ex_mem_to_reg;
  logic          ex_branch_taken;
  logic          mem_access;
  logic          mem_ready;
  logic          stall_out;
  logic          execution_empty_out;
  logic          set_nop_out;
  logic          flush_fetch_out;
  logic [CW-1:0] stall_cycles_out;

  int n_checks;
  int n_fails;

  // Reference model: remaining-cycle bookkeeping for each kind of hold.
  int m_mul_left;
  bit m_mem_wait;
  int m_flush_left;
  int m_count;

  pipeline_hazard_controller #(
    .REGISTER_INDEX_WIDTH(RW),
    .MUL_LATENCY(MUL_L),
    .FLUSH_CYCLES(FLUSH_C),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dec_valid(dec_valid),
    .dec_rs1(dec_rs1),
    .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1),
    .dec_uses_rs2(dec_uses_rs2),
    .dec_is_mul(dec_is_mul),
    .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access),
    .mem_ready(mem_ready),
    .stall_out(stall_out),
    .execution_empty_out(execution_empty_out),
    .set_nop_out(set_nop_out),
    .flush_fetch_out(flush_fetch_out),
    .stall_cycles_out(stall_cycles_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    dec_valid       = 1'b0;
    dec_rs1         = '0;
    dec_rs2         = '0;
    dec_uses_rs1    = 1'b0;
    dec_uses_rs2    = 1'b0;
    dec_is_mul      = 1'b0;
    ex_dest         = '0;
    ex_reg_write    = 1'b0;
    ex_mem_to_reg   = 1'b0;
    ex_branch_taken = 1'b0;
    mem_access      = 1'b0;
    mem_ready       = 1'b0;
  endtask

  // One clock cycle: compare outputs against the model at negedge, advance model, move past posedge.
  task automatic step();
    logic e_stall, e_empty, e_nop, e_flush;
    bit   miss_w, lu;
    @(negedge clk);
    miss_w = mem_access && !mem_ready;
    lu = ex_mem_to_reg && ex_reg_write && (ex_dest != 0) && dec_valid &&
         ((dec_uses_rs1 && dec_rs1 == ex_dest) || (dec_uses_rs2 && dec_rs2 == ex_dest));
    e_stall = 1'b0; e_empty = 1'b1; e_nop = 1'b0; e_flush = 1'b0;
    if (reset) begin
      m_mul_left = 0; m_mem_wait = 0; m_flush_left = 0; m_count = 0;
    end else begin
      if (m_mul_left > 0) begin
        e_stall = 1'b1; e_empty = 1'b0;
        if (!miss_w) m_mul_left--;
      end else if (m_mem_wait) begin
        e_stall = !mem_ready; e_empty = mem_ready;
        if (mem_ready) m_mem_wait = 0;
      end else if (m_flush_left > 0) begin
        e_nop = 1'b1; e_flush = 1'b1;
        m_flush_left--;
      end else if (ex_branch_taken) begin
        e_nop = 1'b1; e_flush = 1'b1;
        m_flush_left = FLUSH_C - 1;
      end else if (miss_w) begin
        e_stall = 1'b1; e_empty = 1'b0;
        m_mem_wait = 1;
      end else if (lu) begin
        e_stall = 1'b1; e_nop = 1'b1;
      end else if (dec_valid && dec_is_mul) begin
        m_mul_left = MUL_L - 1;
      end
      check_eq("stall", stall_out, e_stall);
      check_eq("exec_empty", execution_empty_out, e_empty);
      check_eq("set_nop", set_nop_out, e_nop);
      check_eq("flush_fetch", flush_fetch_out, e_flush);
      check_eq("stall_cycles", stall_cycles_out, m_count);
      if (e_stall && m_count < CMAX) m_count++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    m_mul_left = 0; m_mem_wait = 0; m_flush_left = 0; m_count = 0;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    step();
    reset = 1'b0;

    // Reset state
    #1;
    check_eq("rst_stall", stall_out, 0);
    check_eq("rst_empty", execution_empty_out, 1);
    check_eq("rst_count", stall_cycles_out, 0);
    step();

    // Reset aborts a multiply in progress
    dec_valid = 1'b1; dec_is_mul = 1'b1;
    step();
    clear_inputs();
    step(); step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    check_eq("mulrst_stall", stall_out, 0);
    check_eq("mulrst_empty", execution_empty_out, 1);
    check_eq("mulrst_count", stall_cycles_out, 0);
    step();

    // Load-use on rs2
    ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd5;
    dec_valid = 1'b1; dec_uses_rs2 = 1'b1; dec_rs2 = 5'd5;
    #1;
    check_eq("lu_stall", stall_out, 1);
    check_eq("lu_nop", set_nop_out, 1);
    step();
    ex_mem_to_reg = 1'b0;
    #1;
    check_eq("lu_clear", stall_out, 0);
    step();
    // Same pattern on register 0: no hazard
    ex_mem_to_reg = 1'b1; ex_dest = 5'd0; dec_rs2 = 5'd0;
    #1;
    check_eq("lu_r0_stall", stall_out, 0);
    check_eq("lu_r0_nop", set_nop_out, 0);
    step();
    clear_inputs();

    // Multiply latency
    reset = 1'b1; step(); reset = 1'b0;
    dec_valid = 1'b1; dec_is_mul = 1'b1;
    #1;
    check_eq("mul_issue_stall", stall_out, 0);
    step();
    clear_inputs();
    for (int i = 1; i < MUL_L; i++) begin
      check_eq("mul_busy_stall", stall_out, 1);
      check_eq("mul_busy_empty", execution_empty_out, 0);
      step();
    end
    check_eq("mul_release", stall_out, 0);
    check_eq("mul_count", stall_cycles_out, MUL_L - 1);
    step();

    // Cache miss for 3 cycles then ready
    reset = 1'b1; step(); reset = 1'b0;
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("miss_stall", stall_out, 1);
      step();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("miss_ready_stall", stall_out, 0);
    check_eq("miss_ready_empty", execution_empty_out, 1);
    step();
    clear_inputs();
    #1;
    check_eq("miss_idle_stall", stall_out, 0);
    check_eq("miss_count", stall_cycles_out, 3);
    step();

    // Taken branch beats a simultaneous load-use
    ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd7;
    dec_valid = 1'b1; dec_uses_rs1 = 1'b1; dec_rs1 = 5'd7;
    ex_branch_taken = 1'b1;
    for (int i = 0; i < FLUSH_C; i++) begin
      #1;
      check_eq("br_nop", set_nop_out, 1);
      check_eq("br_flush", flush_fetch_out, 1);
      check_eq("br_stall", stall_out, 0);
      step();
    end
    clear_inputs();
    #1;
    check_eq("br_done_nop", set_nop_out, 0);
    check_eq("br_done_flush", flush_fetch_out, 0);
    step();

    // Counter saturation
    reset = 1'b1; step(); reset = 1'b0;
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("sat_count", stall_cycles_out, CMAX);
    step();
    check_eq("sat_hold", stall_cycles_out, CMAX);
    mem_ready = 1'b1;
    step();
    clear_inputs();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 59) == 0);
      dec_valid       = ($urandom_range(0, 9) < 8);
      dec_rs1         = RW'($urandom_range(0, 3));
      dec_rs2         = RW'($urandom_range(0, 3));
      dec_uses_rs1    = $urandom_range(0, 1);
      dec_uses_rs2    = $urandom_range(0, 1);
      dec_is_mul      = ($urandom_range(0, 6) == 0);
      ex_dest         = RW'($urandom_range(0, 3));
      ex_reg_write    = ($urandom_range(0, 3) != 0);
      ex_mem_to_reg   = $urandom_range(0, 1);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      mem_access      = ($urandom_range(0, 3) == 0);
      mem_ready       = $urandom_range(0, 1);
      step();
    end
    reset = 1'b0;
    clear_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
